// File: rtl/keypad_entry.sv
// Keypad front end for door_lock. It synchronises and debounces the digit and clear buttons,
// pairs two digit presses into one 8-bit code, and drops a half-finished entry on clear or
// after an inactivity timeout.
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_press_raw,
    input  logic [3:0] i_digit,
    input  logic       i_clr_raw,
    output logic [7:0] o_key,
    output logic       o_key_valid,
    output logic [1:0] o_digit_cnt,
    output logic       o_timeout
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TmW = $clog2(TIMEOUT_CYCLES);
    localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES);
    localparam logic [TmW-1:0] TmLast = TmW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StFirst} state_e;

    logic           r_press_s1, r_press_s2;
    logic           r_clr_s1, r_clr_s2;
    logic [3:0]     r_digit_s1, r_digit_s2;

    // Index 0 is the digit button, index 1 the clear button.
    logic [1:0]     w_sync;
    logic [1:0]     r_db_state;
    logic [DbW-1:0] r_db_cnt [2];
    logic [1:0]     w_rise;
    logic           w_press_evt, w_clr_evt;

    state_e         r_state;
    logic [3:0]     r_hi;
    logic [TmW-1:0] r_timer;
    logic [7:0]     r_key;
    logic           r_key_valid;
    logic [1:0]     r_digit_cnt;
    logic           r_timeout;

    // Two-flop synchronisers for both buttons and the digit bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_press_s1 <= 1'b0;
            r_press_s2 <= 1'b0;
            r_clr_s1   <= 1'b0;
            r_clr_s2   <= 1'b0;
            r_digit_s1 <= 4'h0;
            r_digit_s2 <= 4'h0;
        end else begin
            r_press_s1 <= i_press_raw;
            r_press_s2 <= r_press_s1;
            r_clr_s1   <= i_clr_raw;
            r_clr_s2   <= r_clr_s1;
            r_digit_s1 <= i_digit;
            r_digit_s2 <= r_digit_s1;
        end
    end

    assign w_sync = {r_clr_s2, r_press_s2};

    // Debounce: the level must differ from the accepted state for DEBOUNCE_CYCLES+1 cycles in
    // a row; the flip happens on the edge after the counter has reached DEBOUNCE_CYCLES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db_state <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_db_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DbMax) begin
                    r_db_state[i] <= w_sync[i];
                    r_db_cnt[i]   <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
                end
            end
        end
    end

    // A single-cycle event on the edge where the debounced state flips from released to pressed.
    always_comb begin
        w_rise = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = w_sync[i] && !r_db_state[i] && (r_db_cnt[i] == DbMax);
        end
    end

    assign w_press_evt = w_rise[0];
    assign w_clr_evt   = w_rise[1];

    // Entry FSM: clear beats a press, and a press beats an expiring timer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_hi        <= 4'h0;
            r_timer     <= '0;
            r_key       <= 8'h00;
            r_key_valid <= 1'b0;
            r_digit_cnt <= 2'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_timeout   <= 1'b0;
            if (w_clr_evt) begin
                r_state     <= StIdle;
                r_digit_cnt <= 2'd0;
                r_timer     <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_press_evt) begin
                            r_hi        <= r_digit_s2;
                            r_digit_cnt <= 2'd1;
                            r_timer     <= '0;
                            r_state     <= StFirst;
                        end
                    end
                    StFirst: begin
                        if (w_press_evt) begin
                            r_key       <= {r_hi, r_digit_s2};
                            r_key_valid <= 1'b1;
                            r_digit_cnt <= 2'd0;
                            r_state     <= StIdle;
                        end else if (r_timer == TmLast) begin
                            r_hi        <= 4'h0;
                            r_timeout   <= 1'b1;
                            r_digit_cnt <= 2'd0;
                            r_state     <= StIdle;
                        end else begin
                            r_timer <= r_timer + TmW'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_key       = r_key;
    assign o_key_valid = r_key_valid;
    assign o_digit_cnt = r_digit_cnt;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with hand-computed expectations (DEBOUNCE=4, TIMEOUT=64).
module tb_keypad_entry;

    logic       clk;
    logic       rst_n;
    logic       press_raw;
    logic [3:0] digit;
    logic       clr_raw;
    logic [7:0] key;
    logic       key_valid;
    logic [1:0] digit_cnt;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int kv_cnt   = 0;
    int to_cnt   = 0;

    keypad_entry #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_press_raw(press_raw),
        .i_digit    (digit),
        .i_clr_raw  (clr_raw),
        .o_key      (key),
        .o_key_valid(key_valid),
        .o_digit_cnt(digit_cnt),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) kv_cnt <= kv_cnt + 1;
            if (timeout)   to_cnt <= to_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_digit(input logic [3:0] d, input int hold, input int rel);
        digit     = d;
        press_raw = 1'b1;
        tick(hold);
        press_raw = 1'b0;
        tick(rel);
    endtask

    task automatic clear_btn(input int hold, input int rel);
        clr_raw = 1'b1;
        tick(hold);
        clr_raw = 1'b0;
        tick(rel);
    endtask

    initial begin
        logic [3:0] bounce;
        bounce    = 4'b1101;
        rst_n     = 1'b0;
        press_raw = 1'b0;
        clr_raw   = 1'b0;
        digit     = 4'h0;
        tick(3);
        check("reset_key", key, 8'h00);
        check("reset_kv", key_valid, 1'b0);
        check("reset_cnt", digit_cnt, 2'd0);
        check("reset_to", timeout, 1'b0);
        rst_n = 1'b1;
        tick(3);

        // Clean presses 4 then 8, with exact latency on the second.
        press_digit(4'h4, 10, 10);
        check("t1_cnt_after_first", digit_cnt, 2'd1);
        digit     = 4'h8;
        press_raw = 1'b1;
        tick(6);
        check("t1_kv_early", key_valid, 1'b0);
        check("t1_key_early", key, 8'h00);
        tick(1);
        check("t1_kv", key_valid, 1'b1);
        check("t1_key", key, 8'h48);
        check("t1_cnt_after_second", digit_cnt, 2'd0);
        tick(1);
        check("t1_kv_one_cycle", key_valid, 1'b0);
        check("t1_key_hold", key, 8'h48);
        tick(2);
        press_raw = 1'b0;
        tick(10);

        // Bouncy press of D: 1,0,1,1,0 then 8 cycles high.
        digit = 4'hD;
        for (int i = 0; i < 5; i++) begin
            press_raw = (i == 4) ? 1'b0 : bounce[i];
            tick(1);
        end
        press_raw = 1'b1;
        tick(8);
        press_raw = 1'b0;
        tick(10);
        check("t2_one_digit", digit_cnt, 2'd1);
        check("t2_no_kv", kv_cnt, 1);
        press_digit(4'h9, 10, 10);
        check("t2_key", key, 8'hD9);
        check("t2_kv_count", kv_cnt, 2);

        // Held button yields one digit only; then clear it.
        press_digit(4'h3, 30, 10);
        check("t2_held_cnt", digit_cnt, 2'd1);
        check("t2_held_kv", kv_cnt, 2);
        clear_btn(10, 10);
        check("t2_clr_cnt", digit_cnt, 2'd0);
        check("t2_clr_key", key, 8'hD9);

        // Timeout: capture after 7 ticks, pulse after 71.
        digit     = 4'hC;
        press_raw = 1'b1;
        tick(7);
        check("t3_captured", digit_cnt, 2'd1);
        tick(3);
        press_raw = 1'b0;
        tick(60);
        check("t3_to_early", timeout, 1'b0);
        check("t3_cnt_early", digit_cnt, 2'd1);
        tick(1);
        check("t3_to", timeout, 1'b1);
        check("t3_cnt", digit_cnt, 2'd0);
        check("t3_key", key, 8'hD9);
        tick(1);
        check("t3_to_one_cycle", timeout, 1'b0);
        check("t3_to_count", to_cnt, 1);

        // Clear mid-entry, then 6,5.
        press_digit(4'h1, 10, 10);
        check("t4_cnt", digit_cnt, 2'd1);
        clear_btn(10, 10);
        check("t4_clr_cnt", digit_cnt, 2'd0);
        press_digit(4'h6, 10, 10);
        press_digit(4'h5, 10, 10);
        check("t4_key", key, 8'h65);
        check("t4_no_to", to_cnt, 1);

        // Clear and press together: press dropped.
        digit     = 4'h7;
        clr_raw   = 1'b1;
        press_raw = 1'b1;
        tick(10);
        clr_raw   = 1'b0;
        press_raw = 1'b0;
        tick(10);
        check("t5_sim_cnt", digit_cnt, 2'd0);
        check("t5_sim_kv", kv_cnt, 3);

        // Second digit lands exactly on the timer-expiry edge.
        press_digit(4'h2, 10, 54);
        digit     = 4'hA;
        press_raw = 1'b1;
        tick(6);
        check("t5_exp_pre_cnt", digit_cnt, 2'd1);
        tick(1);
        check("t5_exp_kv", key_valid, 1'b1);
        check("t5_exp_key", key, 8'h2A);
        check("t5_exp_to", timeout, 1'b0);
        tick(3);
        press_raw = 1'b0;
        tick(10);
        check("t5_exp_to_count", to_cnt, 1);

        // Async reset mid-entry.
        press_digit(4'h6, 10, 10);
        press_digit(4'h5, 10, 10);
        press_digit(4'h4, 10, 10);
        check("t6_pre_key", key, 8'h65);
        check("t6_pre_cnt", digit_cnt, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_key", key, 8'h00);
        check("t6_rst_cnt", digit_cnt, 2'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t6_kv_total", kv_cnt, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Upstream front end of door_lock: turns raw keypad button activity into the 8-bit `key` code that door_lock consumes.
- Synchronises and debounces the asynchronous press and clear buttons.
- Assembles two 4-bit digit presses into one 8-bit code and holds it stable on `key` until the next complete entry.
- Discards a half-finished entry on clear or on an inactivity timeout.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-stable cycles required to accept a press or release (min 2)
TIMEOUT_CYCLES, 64, cycles allowed between first and second digit before the partial entry is discarded (min 4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
press_raw  input  1  raw digit-button contact, asynchronous, bouncy, active-high
digit  input  4  digit value of the pressed button; stable for the whole time press_raw is high
clr_raw  input  1  raw clear-button contact, asynchronous, bouncy, active-high
key  output  8  last completed code {first_digit, second_digit}; feeds door_lock key
key_valid  output  1  one-cycle pulse on the cycle `key` takes a new value
digit_cnt  output  2  digits held in the current partial entry (0 or 1)
timeout  output  1  one-cycle pulse when a partial entry is discarded by timeout

Behaviour:
- Reset (rst=0, asynchronous): key=8'h00, key_valid=0, digit_cnt=0, timeout=0, FSM=IDLE. All synchronisers, debounce counters and the timer are cleared; both debouncers are in the released state. Deassertion takes effect on the next clk edge.
- Synchronisation: press_raw, clr_raw and digit each pass through a 2-flop synchroniser.
- Debounce, identical per button:
  - A counter counts consecutive cycles in which the synchronised level differs from the debounced state. It resets to 0 whenever the level matches the debounced state.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips.
  - A 0->1 flip produces a single-cycle event (press_evt or clr_evt). A 1->0 flip produces no event.
  - Holding a button produces exactly one event. A new event requires a debounced release first.
- Latency: k = first edge that samples press_raw=1, with the input then held high. press_evt is active for the edge k+DEBOUNCE_CYCLES+2, and the FSM/outputs update on that edge. The synchronised digit is captured on the same edge.
- FSM states IDLE and FIRST:
  - IDLE + press_evt: hi <= digit, digit_cnt <= 1, timer <= 0, go to FIRST.
  - FIRST + press_evt: key <= {hi, digit}, key_valid <= 1 for one cycle, digit_cnt <= 0, go to IDLE.
  - FIRST, no event: timer increments each cycle. When timer == TIMEOUT_CYCLES-1: drop hi, timeout <= 1 for one cycle, digit_cnt <= 0, go to IDLE. key is unchanged.
  - clr_evt in any state: go to IDLE, digit_cnt <= 0, timer <= 0, key unchanged, no pulses.
- Simultaneous events: clr_evt has priority over press_evt in the same cycle; the press is dropped. press_evt on the exact cycle the timer expires is accepted as the second digit, and timeout does not pulse.
- All 16 digit values are legal; no range check.
- key changes only together with key_valid, so door_lock never sees a half-built code.
- Reset mid-entry discards the partial entry and returns key to 8'h00.

Test Plan:
- Reset then clean presses: digit=4 held 10 cycles, released 10, then digit=8 held 10 -> key=8'h48 with a one-cycle key_valid exactly DEBOUNCE_CYCLES+2=6 edges after the second press starts; digit_cnt sequence 0->1->0.
- Bounce: press_raw toggles 1,0,1,1,0 then holds 1 for 8 cycles, digit=D, followed by a clean digit=9 press -> exactly one accepted digit from the bouncy press; key=8'hD9; a held button never yields a second digit.
- Timeout: one press of digit=C, then idle 64 cycles -> timeout pulses once 64 cycles after capture, digit_cnt=0, key retains prior value 8'hD9.
- Clear mid-entry: press digit=1, clear pulse, then presses 6,5 -> key=8'h65; digit 1 discarded; no timeout pulse.
- Simultaneous: clr_raw and press_raw rise together, both with clean edges -> press dropped, digit_cnt=0. Second digit arriving on the timer-expiry cycle -> key updates, timeout stays 0.
- Async reset while digit_cnt=1 and key=8'h65 -> immediately key=8'h00, digit_cnt=0, without waiting for a clk edge.
